// File: rtl/dis_wakeup_queue.sv
// dis_wakeup_queue
// In-order dispatch queue between decode and the reservation stations.
// Entries carry two source operands that are either ready (value held) or
// pending on a ROB tag. Pending sources snoop the CDB every cycle and capture
// the broadcast data. The head entry also sees same-cycle CDB hits, so it can
// leave already woken.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_flush                   synchronous squash of every entry
//   i_in_*  / o_in_ready      enqueue side (operands, ROB number, payload)
//   i_cdb_valid/tag/data      NUM_CDB broadcast ports, port 0 in the LSBs
//   o_out_* / i_out_ready     dequeue side (head entry, zeroed when empty)
//   o_count                   current occupancy
module dis_wakeup_queue #(
    parameter  int DEPTH     = 8,
    parameter  int NUM_CDB   = 2,
    parameter  int ROB_DEPTH = 32,
    parameter  int PAYLOAD_W = 64,
    localparam int TAG_W     = $clog2(ROB_DEPTH),
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic                     i_in_rs1_busy,
    input  logic                     i_in_rs2_busy,
    input  logic [31:0]              i_in_rs1_v,
    input  logic [31:0]              i_in_rs2_v,
    input  logic [TAG_W-1:0]         i_in_rob_num,
    input  logic [PAYLOAD_W-1:0]     i_in_payload,
    input  logic [NUM_CDB-1:0]       i_cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] i_cdb_tag,
    input  logic [NUM_CDB*32-1:0]    i_cdb_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_out_rs1_rdy,
    output logic                     o_out_rs2_rdy,
    output logic [31:0]              o_out_rs1_data,
    output logic [31:0]              o_out_rs2_data,
    output logic [TAG_W-1:0]         o_out_rs1_tag,
    output logic [TAG_W-1:0]         o_out_rs2_tag,
    output logic [TAG_W-1:0]         o_out_rob_num,
    output logic [PAYLOAD_W-1:0]     o_out_payload,
    output logic [CNT_W-1:0]         o_count
);

    logic [PTR_W-1:0]     r_head, r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [DEPTH-1:0]     r_rs1_rdy, r_rs2_rdy;
    logic [31:0]          r_rs1_data [DEPTH];
    logic [31:0]          r_rs2_data [DEPTH];
    logic [TAG_W-1:0]     r_rs1_tag  [DEPTH];
    logic [TAG_W-1:0]     r_rs2_tag  [DEPTH];
    logic [TAG_W-1:0]     r_rob      [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload  [DEPTH];

    logic        w_in_ready, w_out_valid, w_enq, w_deq;
    logic [32:0] w_enq_m1, w_enq_m2;
    logic [32:0] w_wk1 [DEPTH];
    logic [32:0] w_wk2 [DEPTH];

    // Returns {hit, data}. Scanning from the top index down lets the
    // lowest-index matching port overwrite the result last, so it wins.
    function automatic logic [32:0] f_cdb_match(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*32-1:0]    data
    );
        logic [32:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && tags[k*TAG_W +: TAG_W] == tag)
                res = {1'b1, data[k*32 +: 32]};
        end
        return res;
    endfunction

    // A dequeue in the same cycle never frees room for an enqueue.
    assign w_in_ready  = (r_count != CNT_W'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_enq       = i_in_valid && w_in_ready && !i_flush;
    assign w_deq       = w_out_valid && i_out_ready && !i_flush;

    always_comb begin
        w_enq_m1 = f_cdb_match(i_in_rs1_v[TAG_W-1:0], i_cdb_valid, i_cdb_tag, i_cdb_data);
        w_enq_m2 = f_cdb_match(i_in_rs2_v[TAG_W-1:0], i_cdb_valid, i_cdb_tag, i_cdb_data);
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1[i] = f_cdb_match(r_rs1_tag[i], i_cdb_valid, i_cdb_tag, i_cdb_data);
            w_wk2[i] = f_cdb_match(r_rs2_tag[i], i_cdb_valid, i_cdb_tag, i_cdb_data);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
        end else if (i_flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
            else if (!w_enq && w_deq) r_count <= r_count - 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_enq && r_tail == PTR_W'(i)) begin
                    r_rs1_rdy[i] <= !i_in_rs1_busy || w_enq_m1[32];
                    r_rs2_rdy[i] <= !i_in_rs2_busy || w_enq_m2[32];
                end else begin
                    if (!r_rs1_rdy[i] && w_wk1[i][32]) r_rs1_rdy[i] <= 1'b1;
                    if (!r_rs2_rdy[i] && w_wk2[i][32]) r_rs2_rdy[i] <= 1'b1;
                end
            end
        end
    end

    // Entry contents need no reset: they are only observed behind a ready
    // bit or the occupancy count, both of which are reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && r_tail == PTR_W'(i)) begin
                r_rs1_data[i] <= i_in_rs1_busy ? w_enq_m1[31:0] : i_in_rs1_v;
                r_rs2_data[i] <= i_in_rs2_busy ? w_enq_m2[31:0] : i_in_rs2_v;
                r_rs1_tag[i]  <= i_in_rs1_busy ? i_in_rs1_v[TAG_W-1:0] : '0;
                r_rs2_tag[i]  <= i_in_rs2_busy ? i_in_rs2_v[TAG_W-1:0] : '0;
                r_rob[i]      <= i_in_rob_num;
                r_payload[i]  <= i_in_payload;
            end else begin
                if (!r_rs1_rdy[i] && w_wk1[i][32]) r_rs1_data[i] <= w_wk1[i][31:0];
                if (!r_rs2_rdy[i] && w_wk2[i][32]) r_rs2_data[i] <= w_wk2[i][31:0];
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_count     = r_count;

    // Head sources still pending pick up a same-cycle CDB hit directly.
    always_comb begin
        o_out_rs1_rdy  = 1'b0;
        o_out_rs2_rdy  = 1'b0;
        o_out_rs1_data = '0;
        o_out_rs2_data = '0;
        o_out_rs1_tag  = '0;
        o_out_rs2_tag  = '0;
        o_out_rob_num  = '0;
        o_out_payload  = '0;
        if (w_out_valid) begin
            o_out_rs1_rdy  = r_rs1_rdy[r_head] || w_wk1[r_head][32];
            o_out_rs2_rdy  = r_rs2_rdy[r_head] || w_wk2[r_head][32];
            o_out_rs1_data = r_rs1_rdy[r_head] ? r_rs1_data[r_head] : w_wk1[r_head][31:0];
            o_out_rs2_data = r_rs2_rdy[r_head] ? r_rs2_data[r_head] : w_wk2[r_head][31:0];
            o_out_rs1_tag  = r_rs1_tag[r_head];
            o_out_rs2_tag  = r_rs2_tag[r_head];
            o_out_rob_num  = r_rob[r_head];
            o_out_payload  = r_payload[r_head];
        end
    end

endmodule

// File: tb/tb_dis_wakeup_queue.sv
module tb_dis_wakeup_queue;
    localparam int DEPTH = 8;
    localparam int NCDB  = 2;
    localparam int TW    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            rs1_busy = 1'b0, rs2_busy = 1'b0;
    logic [31:0]     rs1_v = '0, rs2_v = '0;
    logic [TW-1:0]   rob_in = '0;
    logic [63:0]     pl_in = '0;
    logic [NCDB-1:0] cdb_valid = '0;
    logic [NCDB*TW-1:0] cdb_tag = '0;
    logic [NCDB*32-1:0] cdb_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            o_r1, o_r2;
    logic [31:0]     o_d1, o_d2;
    logic [TW-1:0]   o_t1, o_t2, o_rob;
    logic [63:0]     o_pl;
    logic [3:0]      count;

    dis_wakeup_queue dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_rs1_busy(rs1_busy), .i_in_rs2_busy(rs2_busy),
        .i_in_rs1_v(rs1_v), .i_in_rs2_v(rs2_v),
        .i_in_rob_num(rob_in), .i_in_payload(pl_in),
        .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_rs1_rdy(o_r1), .o_out_rs2_rdy(o_r2),
        .o_out_rs1_data(o_d1), .o_out_rs2_data(o_d2),
        .o_out_rs1_tag(o_t1), .o_out_rs2_tag(o_t2),
        .o_out_rob_num(o_rob), .o_out_payload(o_pl), .o_count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: an ordered list of entries
    typedef struct {
        logic [TW-1:0] rob;
        logic [63:0]   pl;
        logic          r1, r2;
        logic [31:0]   d1, d2;
        logic [TW-1:0] t1, t2;
    } ent_t;

    ent_t q[$];

    // First (lowest-numbered) valid CDB port broadcasting this tag.
    function automatic logic [32:0] lookup(input logic [TW-1:0] tag);
        for (int k = 0; k < NCDB; k++) begin
            if (cdb_valid[k] && cdb_tag[k*TW +: TW] == tag)
                return {1'b1, cdb_data[k*32 +: 32]};
        end
        return 33'd0;
    endfunction

    ent_t        m_e;
    logic [32:0] m_h;
    bit          m_deq, m_enq;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            m_deq = (q.size() != 0) && out_ready;
            m_enq = (q.size() < DEPTH) && in_valid;
            for (int j = 0; j < q.size(); j++) begin
                if (!q[j].r1) begin m_h = lookup(q[j].t1); if (m_h[32]) begin q[j].r1 = 1'b1; q[j].d1 = m_h[31:0]; end end
                if (!q[j].r2) begin m_h = lookup(q[j].t2); if (m_h[32]) begin q[j].r2 = 1'b1; q[j].d2 = m_h[31:0]; end end
            end
            if (m_deq) void'(q.pop_front());
            if (m_enq) begin
                m_e.rob = rob_in;
                m_e.pl  = pl_in;
                m_h = lookup(rs1_v[TW-1:0]);
                m_e.r1 = !rs1_busy || m_h[32];
                m_e.d1 = !rs1_busy ? rs1_v : (m_h[32] ? m_h[31:0] : 32'd0);
                m_e.t1 = rs1_busy ? rs1_v[TW-1:0] : '0;
                m_h = lookup(rs2_v[TW-1:0]);
                m_e.r2 = !rs2_busy || m_h[32];
                m_e.d2 = !rs2_busy ? rs2_v : (m_h[32] ? m_h[31:0] : 32'd0);
                m_e.t2 = rs2_busy ? rs2_v[TW-1:0] : '0;
                q.push_back(m_e);
            end
        end
    end

    // ---------------- per-cycle comparison against the model
    ent_t        c_e;
    logic [32:0] c_h1, c_h2;

    always @(negedge clk) begin
        check("count", 64'(count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() == 0) begin
            check("rs1_rdy_empty", 64'(o_r1), 64'd0);
            check("rs2_rdy_empty", 64'(o_r2), 64'd0);
            check("data_empty", {o_d1, o_d2}, 64'd0);
            check("tag_rob_empty", 64'({o_t1, o_t2, o_rob}), 64'd0);
            check("payload_empty", o_pl, 64'd0);
        end else begin
            c_e  = q[0];
            c_h1 = lookup(c_e.t1);
            c_h2 = lookup(c_e.t2);
            check("rob", 64'(o_rob), 64'(c_e.rob));
            check("payload", o_pl, c_e.pl);
            check("rs1_rdy", 64'(o_r1), 64'(c_e.r1 || c_h1[32]));
            check("rs2_rdy", 64'(o_r2), 64'(c_e.r2 || c_h2[32]));
            check("rs1_data", 64'(o_d1), 64'(c_e.r1 ? c_e.d1 : c_h1[31:0]));
            check("rs2_data", 64'(o_d2), 64'(c_e.r2 ? c_e.d2 : c_h2[31:0]));
            check("rs1_tag", 64'(o_t1), 64'(c_e.t1));
            check("rs2_tag", 64'(o_t2), 64'(c_e.t2));
        end
    end

    // ---------------- directed stimulus
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rs1_busy = 1'b0; rs2_busy = 1'b0; rs1_v = '0; rs2_v = '0;
        rob_in = '0; pl_in = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic enq(input logic [TW-1:0] rob, input logic b1, input logic [31:0] v1,
                       input logic b2, input logic [31:0] v2);
        in_valid = 1'b1; rob_in = rob;
        rs1_busy = b1; rs1_v = v1; rs2_busy = b2; rs2_v = v2;
        pl_in = 64'hA5A5_0000_0000_0000 | 64'(rob);
    endtask

    int max_cnt;

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) cyc();
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        cyc();

        // Fill to DEPTH, then a ninth request that must be refused.
        for (int k = 0; k < DEPTH; k++) begin
            enq(TW'(k), 1'b0, 32'h100 + 32'(k), 1'b0, 32'h200 + 32'(k));
            cyc();
        end
        enq(5'd9, 1'b0, 32'h999, 1'b0, 32'h999);
        cyc();
        check("fill_count", 64'(count), 64'd8);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        idle();
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("drain_rob", 64'(o_rob), 64'(k));
            check("drain_rs1", 64'(o_d1), 64'h100 + 64'(k));
            cyc();
        end
        idle();
        check("drain_count", 64'(count), 64'd0);

        // Wakeup while queued, on port 1.
        enq(5'd1, 1'b1, 32'd5, 1'b0, 32'h77);
        cyc();
        idle();
        check("wk_pending", 64'(o_r1), 64'd0);
        cyc();
        cdb_valid = 2'b10; cdb_tag = {5'd5, 5'd0}; cdb_data = {32'hDEADBEEF, 32'h0};
        cyc();
        idle();
        check("wk_rdy", 64'(o_r1), 64'd1);
        check("wk_data", 64'(o_d1), 64'hDEADBEEF);
        out_ready = 1'b1;
        cyc();
        idle();

        // Capture at enqueue; a later broadcast of the same tag is ignored.
        enq(5'd2, 1'b0, 32'h55, 1'b1, 32'd3);
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd3}; cdb_data = {32'h0, 32'h12};
        cyc();
        idle();
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd3}; cdb_data = {32'h0, 32'h99};
        cyc();
        idle();
        check("byp_rdy", 64'(o_r2), 64'd1);
        check("byp_data", 64'(o_d2), 64'h12);
        out_ready = 1'b1;
        cyc();
        idle();

        // Both ports hit one tag: port 0 wins.
        enq(5'd3, 1'b1, 32'd9, 1'b0, 32'h1);
        cyc();
        idle();
        cdb_valid = 2'b11; cdb_tag = {5'd9, 5'd9}; cdb_data = {32'h222, 32'h111};
        cyc();
        idle();
        check("prio_data", 64'(o_d1), 64'h111);
        out_ready = 1'b1;
        cyc();
        idle();

        // Head forwarding in the dequeue cycle.
        enq(5'd4, 1'b1, 32'd7, 1'b0, 32'h2);
        cyc();
        idle();
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd7}; cdb_data = {32'h0, 32'h40};
        out_ready = 1'b1;
        #1;
        check("fwd_rdy", 64'(o_r1), 64'd1);
        check("fwd_data", 64'(o_d1), 64'h40);
        check("fwd_rob", 64'(o_rob), 64'd4);
        cyc();
        idle();
        check("fwd_count", 64'(count), 64'd0);

        // Wrap: steady-state enqueue+dequeue pairs.
        enq(5'd10, 1'b0, 32'h1000, 1'b0, 32'h2000);
        cyc();
        max_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            enq(TW'(11 + k), 1'b0, 32'h1000 + 32'(k + 1), 1'b0, 32'h2000 + 32'(k + 1));
            out_ready = 1'b1;
            check("wrap_rob", 64'(o_rob), 64'(10 + k));
            cyc();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        check("wrap_maxcount", 64'(max_cnt), 64'd1);
        idle();
        out_ready = 1'b1;
        cyc();
        idle();

        // Flush beats a simultaneous enqueue.
        for (int k = 0; k < 5; k++) begin
            enq(TW'(k), 1'b1, 32'd20, 1'b0, 32'h3);
            cyc();
        end
        idle();
        check("flush_pre", 64'(count), 64'd5);
        flush = 1'b1;
        enq(5'd25, 1'b0, 32'h1, 1'b0, 32'h1);
        cyc();
        idle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        enq(5'd6, 1'b1, 32'd20, 1'b0, 32'h4);
        cyc();
        idle();
        check("flush_notrdy", 64'(o_r1), 64'd0);

        // Asynchronous reset mid-stream, checked before any clock edge.
        for (int k = 0; k < 3; k++) begin
            enq(TW'(k + 1), 1'b0, 32'h5, 1'b0, 32'h6);
            cyc();
        end
        idle();
        #1;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dis_wakeup_queue.md
DIS_WAKEUP_QUEUE -- requirements
Module: dis_wakeup_queue

Parameters
REQ-001 DEPTH, 8, number of queue entries; power of two, at least 2.
REQ-002 NUM_CDB, 2, number of common-data-bus broadcast ports; at least 1.
REQ-003 ROB_DEPTH, 32, ROB entry count; TAG_W = $clog2(ROB_DEPTH).
REQ-004 PAYLOAD_W, 64, width of the opaque decode payload carried through unmodified.

Interface
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 flush  in  1  synchronous squash of all queue contents.
REQ-008 in_valid / in_ready  in / out  1 / 1  enqueue handshake from decode.
REQ-009 in_rs1_busy, in_rs2_busy  in  1 each  source is pending in the ROB.
REQ-010 in_rs1_v, in_rs2_v  in  32 each  operand value; when busy, bits [TAG_W-1:0] hold the ROB tag.
REQ-011 in_rob_num  in  TAG_W  destination ROB tag; in_payload  in  PAYLOAD_W  passthrough.
REQ-012 cdb_valid  in  NUM_CDB  per-port broadcast valid.
REQ-013 cdb_tag  in  NUM_CDB*TAG_W  packed, port 0 in the LSBs; cdb_data  in  NUM_CDB*32  packed likewise.
REQ-014 out_valid / out_ready  out / in  1 / 1  dequeue handshake to the reservation stations.
REQ-015 out_rs1_rdy, out_rs2_rdy  out  1 each; out_rs1_data, out_rs2_data  out  32 each; out_rs1_tag, out_rs2_tag  out  TAG_W each.
REQ-016 out_rob_num  out  TAG_W; out_payload  out  PAYLOAD_W; count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 The queue SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus an occupancy counter.
REQ-018 in_ready SHALL equal (count < DEPTH); a same-cycle dequeue SHALL NOT free a slot for a same-cycle enqueue.
REQ-019 An enqueue SHALL occur when in_valid && in_ready && !flush, writing the entry at tail and advancing tail by one.
REQ-020 On enqueue, a non-busy source SHALL be stored ready with in_rsX_v.
REQ-021 On enqueue, a busy source SHALL be stored ready with cdb_data if any valid CDB port's tag equals in_rsX_v[TAG_W-1:0]; otherwise it SHALL be stored not-ready with that tag.
REQ-022 Every cycle, each stored not-ready source SHALL compare its tag against all valid CDB ports; on a match it SHALL latch the data and become ready at the next edge.
REQ-023 If several CDB ports match one tag in the same cycle, the lowest-index port SHALL win.
REQ-024 out_valid SHALL equal (count != 0); out_* SHALL present the head entry.
REQ-025 A not-ready head source SHALL be forwarded combinationally: out_rsX_rdy=1 and out_rsX_data=cdb data when a valid CDB port matches in that cycle.
REQ-026 A dequeue SHALL occur when out_valid && out_ready && !flush; head SHALL advance by one.
REQ-027 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-028 Minimum enqueue-to-out_valid latency SHALL be one cycle; there is no flow-through path from an empty queue.
REQ-029 When out_valid=0, all out_* data fields SHALL be 0.
REQ-030 flush SHALL take priority over enqueue, dequeue and wakeup: next edge head=tail=0, count=0, and all entry ready bits cleared.
REQ-031 Entries not at head SHALL remain in order; there SHALL be no out-of-order issue from this block.

Reset
REQ-032 While rst is high: head=0, tail=0, count=0, all entry ready bits 0, out_valid=0, in_ready=1, out_* data fields 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-034 Fill: 8 enqueues with no dequeue, DEPTH=8 -> count=8, in_ready=0; a 9th in_valid is ignored; then 8 dequeues return rob_num 0..7 in order.
REQ-035 Wakeup in queue: enqueue rs1 busy with tag 5; two cycles later cdb_valid[1]=1, cdb_tag[1]=5, data 0xDEADBEEF -> next cycle out_rs1_rdy=1, out_rs1_data=0xDEADBEEF.
REQ-036 Enqueue bypass: busy rs2 with tag 3 while port 0 broadcasts tag 3, data 0x12 -> the entry dequeues with out_rs2_rdy=1 and data 0x12; a later broadcast of tag 3 does not alter it.
REQ-037 Head forward: head rs1 not ready with tag 7; CDB broadcasts tag 7, data 0x40 in the same cycle out_ready=1 -> dequeued with rs1_rdy=1 and data 0x40.
REQ-038 Wrap: 12 interleaved enqueue/dequeue pairs at DEPTH=8 -> order preserved and count never exceeds 8.
REQ-039 Flush: with count=5, assert flush together with in_valid -> next cycle count=0, out_valid=0; rst pulsed mid-stream -> count=0 with no clock edge.
